// File: rtl/seg_pkg.sv
// seg_pkg: shared types and constants for the seven-segment scanner.
//   state_e   - scanner FSM states
//   SEG_*     - 7-bit active-low segment patterns, bit order {g,f,e,d,c,b,a}
package seg_pkg;

  typedef enum logic [1:0] {
    S_OFF,
    S_GAP,
    S_ON
  } state_e;

  // Active-low: a 0 bit lights the segment.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/bcd_to_seg.sv
// bcd_to_seg: combinational 4-bit code to active-low seven-segment decoder.
//   code  in  4 : BCD code; 10..15 render as a dash
//   seg   out 7 : {g,f,e,d,c,b,a}, active low
module bcd_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    unique case (code)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_scan.sv
// seg_scan: multiplexed seven-segment scanner with frame-buffered digits,
// anti-ghosting gap between digits and optional leading-zero blanking.
//   clk_in      in  1          : system clock
//   rst_n       in  1          : asynchronous active-low reset
//   scan_clk    in  1          : divided scan clock, sampled as data
//   bcd_in      in  4*DIGITS   : digit i at [4i+3:4i], digit 0 least significant
//   dp_in       in  DIGITS     : decimal point per digit, 1 = lit
//   bcd_valid   in  1          : load strobe for bcd_in/dp_in
//   an_n        out DIGITS     : digit enables, active low
//   seg_n       out 8          : {dp,g,f,e,d,c,b,a}, active low
//   frame_done  out 1          : pulse when the digit index wraps
module seg_scan
  import seg_pkg::*;
#(
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned GHOST_CYCLES = 2,
  parameter int unsigned BLANK_LZ     = 1
) (
  input  logic                  clk_in,
  input  logic                  rst_n,
  input  logic                  scan_clk,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  bcd_valid,
  output logic [DIGITS-1:0]     an_n,
  output logic [7:0]            seg_n,
  output logic                  frame_done
);

  localparam int unsigned     IdxW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DIGITS - 1);
  localparam logic [7:0]      GapLast = 8'(GHOST_CYCLES - 1);

  // Scan clock synchronizer and registered rising-edge detect.
  logic sync0_q, sync1_q, sync1_prev_q, step_q;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync0_q      <= 1'b0;
      sync1_q      <= 1'b0;
      sync1_prev_q <= 1'b0;
      step_q       <= 1'b0;
    end else begin
      sync0_q      <= scan_clk;
      sync1_q      <= sync0_q;
      sync1_prev_q <= sync1_q;
      step_q       <= sync1_q & ~sync1_prev_q;
    end
  end

  // Scanner FSM.
  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [7:0]      gap_q, gap_d;
  logic            wrap;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    wrap    = 1'b0;
    unique case (state_q)
      S_OFF: begin
        if (step_q) begin
          state_d = S_GAP;
          idx_d   = '0;
          gap_d   = '0;
        end
      end
      S_GAP: begin
        // Steps landing here are dropped; the gap length is fixed.
        if (gap_q == GapLast) state_d = S_ON;
        else                  gap_d   = gap_q + 8'd1;
      end
      S_ON: begin
        if (step_q) begin
          state_d = S_GAP;
          gap_d   = '0;
          if (idx_q == LastIdx) begin
            idx_d = '0;
            wrap  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = S_OFF;
    endcase
  end

  // Pending/display double buffer; display only changes on a frame wrap.
  logic [DIGITS-1:0][3:0] disp_bcd_q, disp_bcd_d, pend_bcd_q, pend_bcd_d;
  logic [DIGITS-1:0]      disp_dp_q, disp_dp_d, pend_dp_q, pend_dp_d;
  logic                   pend_flag_q, pend_flag_d;

  always_comb begin
    disp_bcd_d  = disp_bcd_q;
    disp_dp_d   = disp_dp_q;
    pend_bcd_d  = pend_bcd_q;
    pend_dp_d   = pend_dp_q;
    pend_flag_d = pend_flag_q;
    if (bcd_valid) begin
      pend_bcd_d  = bcd_in;
      pend_dp_d   = dp_in;
      pend_flag_d = 1'b1;
    end
    if (wrap) begin
      // A load on the wrap cycle bypasses the pending stage.
      if (bcd_valid) begin
        disp_bcd_d = bcd_in;
        disp_dp_d  = dp_in;
      end else if (pend_flag_q) begin
        disp_bcd_d = pend_bcd_q;
        disp_dp_d  = pend_dp_q;
      end
      pend_flag_d = 1'b0;
    end
  end

  // Leading-zero mask: digit i blanks when it and all higher digits are 0.
  logic [DIGITS-1:0] blank;

  always_comb begin
    logic all_zero;
    all_zero = 1'b1;
    blank    = '0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      all_zero = all_zero & (disp_bcd_q[i] == 4'd0);
      blank[i] = (BLANK_LZ != 0) && (i > 0) && all_zero;
    end
  end

  logic [6:0] cur_seg;

  bcd_to_seg u_dec (
    .code (disp_bcd_q[idx_q]),
    .seg  (cur_seg)
  );

  // Outputs are registered from next state so they move with the FSM.
  logic [DIGITS-1:0] an_d;
  logic [7:0]        seg_d;

  always_comb begin
    an_d  = '1;
    seg_d = 8'hFF;
    if (state_d == S_ON) begin
      an_d[idx_q] = 1'b0;
      seg_d       = {~disp_dp_q[idx_q], blank[idx_q] ? SEG_BLANK : cur_seg};
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_OFF;
      idx_q       <= '0;
      gap_q       <= '0;
      disp_bcd_q  <= '0;
      disp_dp_q   <= '0;
      pend_bcd_q  <= '0;
      pend_dp_q   <= '0;
      pend_flag_q <= 1'b0;
      an_n        <= '1;
      seg_n       <= 8'hFF;
      frame_done  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      gap_q       <= gap_d;
      disp_bcd_q  <= disp_bcd_d;
      disp_dp_q   <= disp_dp_d;
      pend_bcd_q  <= pend_bcd_d;
      pend_dp_q   <= pend_dp_d;
      pend_flag_q <= pend_flag_d;
      an_n        <= an_d;
      seg_n       <= seg_d;
      frame_done  <= wrap;
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan: self-checking bench for seg_scan (4 digits, 4-cycle ghost gap).
module tb_seg_scan;

  localparam int DIG   = 4;
  localparam int GHOST = 4;

  // Active-high {g..a} patterns straight from a seven-segment datasheet.
  localparam logic [6:0] SEG_HI [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40
  };

  logic        clk_in = 1'b0;
  logic        rst_n;
  logic        scan_clk;
  logic [15:0] bcd_in;
  logic [3:0]  dp_in;
  logic        bcd_valid;
  logic [3:0]  an_n;
  logic [7:0]  seg_n;
  logic        frame_done;

  int n_cmp  = 0;
  int n_fail = 0;
  int sc_half = 0;

  seg_scan #(
    .DIGITS       (DIG),
    .GHOST_CYCLES (GHOST),
    .BLANK_LZ     (1)
  ) dut (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .scan_clk   (scan_clk),
    .bcd_in     (bcd_in),
    .dp_in      (dp_in),
    .bcd_valid  (bcd_valid),
    .an_n       (an_n),
    .seg_n      (seg_n),
    .frame_done (frame_done)
  );

  always #5 clk_in = ~clk_in;

  // Behavioural model: which digit is lit (if any), when the gap started,
  // what the frame shows and what is waiting for the next frame.
  typedef struct {
    bit          started;
    bit          lit;
    int          digit;
    int          cyc;
    int          gap_start;
    logic [15:0] shown;
    logic [3:0]  shown_dp;
    logic [15:0] pend;
    logic [3:0]  pend_dp;
    bit          have_pend;
    bit          fd;
    logic [3:0]  hist;   // scan_clk samples, [0] newest
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r.started = 0; r.lit = 0; r.digit = 0; r.cyc = 0; r.gap_start = 0;
    r.shown = '0; r.shown_dp = '0; r.pend = '0; r.pend_dp = '0;
    r.have_pend = 0; r.fd = 0; r.hist = '0;
    return r;
  endfunction

  // A scan_clk rise becomes a step three clock edges later.
  function automatic bit step_pending(model_t c);
    return c.hist[2] && !c.hist[3];
  endfunction

  function automatic model_t model_next(model_t c, logic sc, logic valid,
                                        logic [15:0] bcd, logic [3:0] dp);
    model_t n;
    bit step;
    bit wrapped;
    n = c;
    step = step_pending(c);
    wrapped = 0;
    n.cyc = c.cyc + 1;
    n.fd = 0;
    if (!c.started) begin
      if (step) begin
        n.started = 1; n.lit = 0; n.digit = 0; n.gap_start = n.cyc;
      end
    end else if (!c.lit) begin
      if (n.cyc - c.gap_start >= GHOST) n.lit = 1;
    end else if (step) begin
      n.lit = 0;
      n.gap_start = n.cyc;
      wrapped = (c.digit == DIG - 1);
      n.digit = (c.digit + 1) % DIG;
      n.fd = wrapped;
    end
    if (wrapped) begin
      if (valid) begin
        n.shown = bcd; n.shown_dp = dp;
      end else if (c.have_pend) begin
        n.shown = c.pend; n.shown_dp = c.pend_dp;
      end
      n.have_pend = 0;
    end else if (valid) begin
      n.pend = bcd; n.pend_dp = dp; n.have_pend = 1;
    end
    n.hist = {c.hist[2:0], sc};
    return n;
  endfunction

  function automatic logic [3:0] exp_an(model_t c);
    return c.lit ? ~(4'b0001 << c.digit) : 4'hF;
  endfunction

  function automatic logic [7:0] exp_seg(model_t c);
    logic [6:0] pat;
    logic       dpb;
    if (!c.lit) return 8'hFF;
    pat = SEG_HI[4'(c.shown >> (4 * c.digit))];
    if (c.digit > 0 && (c.shown >> (4 * c.digit)) == 16'd0) pat = 7'h00;
    dpb = 1'(c.shown_dp >> c.digit);
    return {~dpb, ~pat};
  endfunction

  always @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) m <= model_reset();
    else        m <= model_next(m, scan_clk, bcd_valid, bcd_in, dp_in);
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk_in) begin
    n_cmp++;
    if (an_n !== exp_an(m) || seg_n !== exp_seg(m) || frame_done !== m.fd) begin
      n_fail++;
      $display("FAIL model t=%0t an_n=%b want %b seg_n=%h want %h frame_done=%b want %b",
               $time, an_n, exp_an(m), seg_n, exp_seg(m), frame_done, m.fd);
    end
  end

  // Free-running scan clock, toggled every sc_half cycles (0 = stopped).
  initial begin
    int cnt;
    cnt = 0;
    scan_clk = 1'b0;
    forever begin
      @(posedge clk_in);
      #1;
      if (sc_half > 0) begin
        cnt++;
        if (cnt >= sc_half) begin
          cnt = 0;
          scan_clk = ~scan_clk;
        end
      end
    end
  end

  task automatic load(input logic [15:0] v, input logic [3:0] dp);
    bcd_in = v;
    dp_in = dp;
    bcd_valid = 1'b1;
    @(posedge clk_in);
    #1;
    bcd_valid = 1'b0;
  endtask

  task automatic wait_frame(input string name);
    int c;
    c = 0;
    @(negedge clk_in);
    while (frame_done !== 1'b1 && c < 400) begin
      @(negedge clk_in);
      c++;
    end
    if (c >= 400) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: frame_done not seen within 400 cycles", name);
    end
  endtask

  task automatic expect_digit(input int d, input logic [7:0] want, input string name);
    int c;
    logic [3:0] pat;
    pat = ~(4'b0001 << d);
    c = 0;
    @(negedge clk_in);
    while (an_n !== pat && c < 200) begin
      @(negedge clk_in);
      c++;
    end
    n_cmp++;
    if (c >= 200 || seg_n !== want) begin
      n_fail++;
      $display("FAIL %s: an_n=%b seg_n=%h, required an_n=%b seg_n=%h", name, an_n, seg_n,
               pat, want);
    end
  endtask

  task automatic wait_an(input logic [3:0] pat, input string name);
    int c;
    c = 0;
    @(negedge clk_in);
    while (an_n !== pat && c < 200) begin
      @(negedge clk_in);
      c++;
    end
    if (c >= 200) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: an_n=%b never reached %b", name, an_n, pat);
    end
  endtask

  initial begin
    int gap_len, c, last, skips, changes, d;
    rst_n = 1'b0;
    bcd_in = '0;
    dp_in = '0;
    bcd_valid = 1'b0;
    repeat (4) @(negedge clk_in);
    n_cmp++;
    if (an_n !== 4'hF || seg_n !== 8'hFF || frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: an_n=%b seg_n=%h fd=%b, required 1111 ff 0", an_n, seg_n,
               frame_done);
    end

    // Reset, then load 1234 with slow scan (period 8).
    rst_n = 1'b1;
    sc_half = 4;
    @(negedge clk_in);
    n_cmp++;
    if (an_n !== 4'hF) begin
      n_fail++;
      $display("FAIL pre_step: an_n=%b, required 1111", an_n);
    end
    load(16'h1234, 4'h0);
    wait_frame("first_wrap");
    gap_len = 1;
    c = 0;
    @(negedge clk_in);
    while (an_n === 4'hF && c < 50) begin
      gap_len++;
      c++;
      @(negedge clk_in);
    end
    n_cmp++;
    if (gap_len != GHOST) begin
      n_fail++;
      $display("FAIL gap_len: got %0d cycles, required %0d", gap_len, GHOST);
    end
    expect_digit(1, 8'hB0, "d1_3");
    expect_digit(2, 8'hA4, "d2_2");
    expect_digit(3, 8'hF9, "d3_1");
    expect_digit(0, 8'h99, "d0_4");

    // Leading-zero blanking.
    load(16'h0070, 4'h0);
    wait_frame("lz_wrap");
    expect_digit(0, 8'hC0, "lz_d0");
    expect_digit(1, 8'hF8, "lz_d1");
    expect_digit(2, 8'hFF, "lz_d2");
    expect_digit(3, 8'hFF, "lz_d3");
    load(16'h0000, 4'h0);
    wait_frame("zero_wrap");
    expect_digit(0, 8'hC0, "zero_d0");
    expect_digit(1, 8'hFF, "zero_d1");

    // Mid-frame load while digit 1 is lit.
    wait_an(4'b1101, "mid_wait");
    load(16'h5678, 4'b0010);
    expect_digit(2, 8'hFF, "mid_old_d2");
    expect_digit(3, 8'hFF, "mid_old_d3");
    wait_frame("mid_wrap");
    expect_digit(0, 8'h80, "mid_new_d0");
    expect_digit(1, 8'h78, "mid_new_d1_dp");

    // Load coinciding with the wrap step.
    c = 0;
    @(negedge clk_in);
    while (!(m.lit && m.digit == 3 && step_pending(m)) && c < 400) begin
      @(negedge clk_in);
      c++;
    end
    if (c >= 400) begin
      n_cmp++;
      n_fail++;
      $display("FAIL wrap_wait: wrap step never approached");
    end
    load(16'h9012, 4'h0);
    expect_digit(0, 8'hA4, "wrapload_d0");
    expect_digit(1, 8'hF9, "wrapload_d1");
    expect_digit(2, 8'hC0, "wrapload_d2");
    n_cmp++;
    if (dut.pend_flag_q !== 1'b0) begin
      n_fail++;
      $display("FAIL wrapload_pend: pend_flag=%b, required 0", dut.pend_flag_q);
    end

    // Fast scan: steps land in the gap and must be dropped.
    sc_half = 2;
    last = -1;
    skips = 0;
    changes = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_in);
      if (an_n !== 4'hF) begin
        d = -1;
        for (int b = 0; b < DIG; b++) if (an_n[b] === 1'b0) d = b;
        if (d != last) begin
          if (last >= 0 && d != (last + 1) % DIG) skips++;
          last = d;
          changes++;
        end
      end
    end
    n_cmp++;
    if (skips != 0 || changes < 8) begin
      n_fail++;
      $display("FAIL fast_scan: skips=%0d changes=%0d, required 0 skips and >=8 changes",
               skips, changes);
    end

    // Asynchronous reset while digit 2 is lit, then a dash.
    sc_half = 4;
    wait_an(4'b1011, "rst_wait");
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (an_n !== 4'hF || seg_n !== 8'hFF) begin
      n_fail++;
      $display("FAIL async_rst: an_n=%b seg_n=%h, required 1111 ff", an_n, seg_n);
    end
    repeat (3) @(negedge clk_in);
    rst_n = 1'b1;
    load(16'h00B0, 4'h0);
    wait_frame("dash_wrap");
    expect_digit(0, 8'hC0, "dash_d0");
    expect_digit(1, 8'hBF, "dash_d1");
    expect_digit(2, 8'hFF, "dash_d2");

    repeat (4) @(negedge clk_in);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
